fwd_sel_ctrl: RTL and testbench

//  Produces the registered 2-bit operand selects that drive the EX-stage operand muxes
//  (one 3-input mux per ALU operand). Tracks destination registers of in-flight instructions

---
 rtl/fwd_pkg.sv | 20 ++
 rtl/fwd_match.sv | 32 +++
 rtl/fwd_sel_ctrl.sv | 139 +++++++++++++
 tb/tb_fwd_sel_ctrl.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fwd_pkg.sv
// Operand forwarding select encodings, FSM states and default widths.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package fwd_pkg;

    localparam int REG_ADDR_W_DEF = 5;
    localparam int SEL_W_DEF      = 2;

    // EX operand mux select: register file, WB result, retire hold slot
    localparam logic [1:0] SEL_RF  = 2'd0;
    localparam logic [1:0] SEL_WB  = 2'd1;
    localparam logic [1:0] SEL_RET = 2'd2;

    // Load-use bubble FSM (only used when FWD_LOAD_STALL_EN is defined)
    typedef enum logic {
        RUN    = 1'b0,
        BUBBLE = 1'b1
    } fsm_state_t;

endpackage

// File: rtl/fwd_match.sv
// Compares one source register against the EX and WB producers and returns its select.
// Latency: combinational.
// Backpressure: none; pure function of its inputs.
module fwd_match
    import fwd_pkg::*;
#(
    parameter int REG_ADDR_W = REG_ADDR_W_DEF,
    parameter int SEL_W      = SEL_W_DEF
) (
    input  logic [REG_ADDR_W-1:0] rs,
    input  logic                  ex_valid,
    input  logic                  ex_wen,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  wb_valid,
    input  logic                  wb_wen,
    input  logic [REG_ADDR_W-1:0] wb_rd,
    output logic [SEL_W-1:0]      sel
);

    // Newest producer wins: EX (moving to WB) beats WB (moving to retire); x0 never forwards
    always_comb begin
        sel = SEL_W'(SEL_RF);
        if (rs == '0) begin
            sel = SEL_W'(SEL_RF);
        end else if (ex_valid && ex_wen && (ex_rd == rs)) begin
            sel = SEL_W'(SEL_WB);
        end else if (wb_valid && wb_wen && (wb_rd == rs)) begin
            sel = SEL_W'(SEL_RET);
        end
    end

endmodule

// File: rtl/fwd_sel_ctrl.sv
// Registered EX operand-mux selects from in-flight destination tracking; optional load-use bubble (FWD_LOAD_STALL_EN).
// Latency: selects and ex_valid one cycle after decode presents; stall_req combinational.
// Backpressure: hold freezes all state (flush still kills EX); stall_req freezes IF/decode for one cycle.
module fwd_sel_ctrl
    import fwd_pkg::*;
#(
    parameter int REG_ADDR_W = REG_ADDR_W_DEF,
    parameter int SEL_W      = SEL_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  dec_valid,
    input  logic [REG_ADDR_W-1:0] dec_rs1,
    input  logic [REG_ADDR_W-1:0] dec_rs2,
    input  logic [REG_ADDR_W-1:0] dec_rd,
    input  logic                  dec_regwen,
    input  logic                  dec_is_load,
    input  logic                  flush,
    input  logic                  hold,
    output logic [SEL_W-1:0]      sel_a,
    output logic [SEL_W-1:0]      sel_b,
    output logic                  ex_valid,
    output logic                  stall_req
);

    // In-flight destination tracking (ex_valid is the EX slot valid itself)
    logic [REG_ADDR_W-1:0] ex_rd;
    logic                  ex_wen;
    logic                  ex_load;
    logic                  wb_valid;
    logic [REG_ADDR_W-1:0] wb_rd;
    logic                  wb_wen;
    logic                  ret_valid;
    logic [REG_ADDR_W-1:0] ret_rd;
    logic                  ret_wen;

    logic [SEL_W-1:0]      sel_a_nxt;
    logic [SEL_W-1:0]      sel_b_nxt;
    logic                  dec_live;

    assign dec_live = dec_valid & ~flush;

    fwd_match #(.REG_ADDR_W(REG_ADDR_W), .SEL_W(SEL_W)) u_match_a (
        .rs       (dec_rs1),
        .ex_valid (ex_valid),
        .ex_wen   (ex_wen),
        .ex_rd    (ex_rd),
        .wb_valid (wb_valid),
        .wb_wen   (wb_wen),
        .wb_rd    (wb_rd),
        .sel      (sel_a_nxt)
    );

    fwd_match #(.REG_ADDR_W(REG_ADDR_W), .SEL_W(SEL_W)) u_match_b (
        .rs       (dec_rs2),
        .ex_valid (ex_valid),
        .ex_wen   (ex_wen),
        .ex_rd    (ex_rd),
        .wb_valid (wb_valid),
        .wb_wen   (wb_wen),
        .wb_rd    (wb_rd),
        .sel      (sel_b_nxt)
    );

`ifdef FWD_LOAD_STALL_EN
    fsm_state_t state;

    // Load in EX feeding the decoding instruction: its data only exists at WB, so insert one bubble
    assign stall_req = (state == RUN) && dec_valid && !flush &&
                       ex_valid && ex_load && ex_wen && (ex_rd != '0) &&
                       ((ex_rd == dec_rs1) || (ex_rd == dec_rs2));

    // RUN/BUBBLE sequencing: flush always returns to RUN, hold freezes, one bubble per stall
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RUN;
        end else if (flush) begin
            state <= RUN;
        end else if (!hold) begin
            state <= stall_req ? BUBBLE : RUN;
        end
    end

    logic unused_sink;
    assign unused_sink = ^{ret_valid, ret_rd, ret_wen};
`else
    // Loads forward from WB like any producer; no bubble is ever needed
    assign stall_req = 1'b0;

    logic unused_sink;
    assign unused_sink = ^{ret_valid, ret_rd, ret_wen, ex_load};
`endif

    // Pipeline advance of the tracked slots and registered operand selects
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid  <= 1'b0;
            ex_rd     <= '0;
            ex_wen    <= 1'b0;
            ex_load   <= 1'b0;
            wb_valid  <= 1'b0;
            wb_rd     <= '0;
            wb_wen    <= 1'b0;
            ret_valid <= 1'b0;
            ret_rd    <= '0;
            ret_wen   <= 1'b0;
            sel_a     <= SEL_W'(SEL_RF);
            sel_b     <= SEL_W'(SEL_RF);
        end else if (hold) begin
            // Frozen, but a redirect must still kill whatever sits in EX
            if (flush) begin
                ex_valid <= 1'b0;
                sel_a    <= SEL_W'(SEL_RF);
                sel_b    <= SEL_W'(SEL_RF);
            end
        end else begin
            wb_valid  <= ex_valid;
            wb_rd     <= ex_rd;
            wb_wen    <= ex_wen;
            ret_valid <= wb_valid;
            ret_rd    <= wb_rd;
            ret_wen   <= wb_wen;
            if (stall_req) begin
                // Bubble into EX; decode keeps its instruction for the next cycle
                ex_valid <= 1'b0;
                sel_a    <= SEL_W'(SEL_RF);
                sel_b    <= SEL_W'(SEL_RF);
            end else begin
                ex_valid <= dec_live;
                ex_rd    <= dec_rd;
                ex_wen   <= dec_regwen;
                ex_load  <= dec_is_load;
                sel_a    <= dec_live ? sel_a_nxt : SEL_W'(SEL_RF);
                sel_b    <= dec_live ? sel_b_nxt : SEL_W'(SEL_RF);
            end
        end
    end

endmodule

// File: tb/tb_fwd_sel_ctrl.sv
// Scoreboard bench for fwd_sel_ctrl: directed hazard sequences plus randomized traffic.
// Expected outputs come from an instruction-queue reference model.
// Honours FWD_LOAD_STALL_EN the same way as the design build.
module tb_fwd_sel_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       dec_valid = 1'b0;
    logic [4:0] dec_rs1 = '0;
    logic [4:0] dec_rs2 = '0;
    logic [4:0] dec_rd = '0;
    logic       dec_regwen = 1'b0;
    logic       dec_is_load = 1'b0;
    logic       flush = 1'b0;
    logic       hold = 1'b0;
    logic [1:0] sel_a;
    logic [1:0] sel_b;
    logic       ex_valid;
    logic       stall_req;

    fwd_sel_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .dec_valid   (dec_valid),
        .dec_rs1     (dec_rs1),
        .dec_rs2     (dec_rs2),
        .dec_rd      (dec_rd),
        .dec_regwen  (dec_regwen),
        .dec_is_load (dec_is_load),
        .flush       (flush),
        .hold        (hold),
        .sel_a       (sel_a),
        .sel_b       (sel_b),
        .ex_valid    (ex_valid),
        .stall_req   (stall_req)
    );

    always #5 clk = ~clk;

    int cyc_cnt = 0;
    always @(posedge clk) cyc_cnt++;

    int errors = 0;
    int checks = 0;

    // Scoreboard entries: what the DUT must show during cycle 'cyc'
    typedef struct {
        int       cyc;
        logic [1:0] sa;
        logic [1:0] sb;
        logic     ev;
    } reg_exp_t;
    typedef struct {
        int   cyc;
        logic st;
    } stall_exp_t;
    reg_exp_t   reg_q[$];
    stall_exp_t stall_q[$];

    // Reference model: instructions in flight, newest first ([0]=EX, [1]=WB, [2]=retire)
    typedef struct {
        bit       live;
        bit       wen;
        bit       load;
        logic [4:0] rd;
    } ins_t;
    ins_t       pipe[$];
    bit         m_bubble;
    logic [1:0] m_sa;
    logic [1:0] m_sb;
    bit         last_stall;

    // Source value comes from the youngest older writer: one stage ahead -> WB result, two -> retire hold
    function automatic logic [1:0] pick(logic [4:0] rs);
        if (rs == 5'd0) return 2'd0;
        for (int d = 0; d < 2; d++) begin
            if (d < pipe.size() && pipe[d].live && pipe[d].wen && pipe[d].rd == rs)
                return (d == 0) ? 2'd1 : 2'd2;
        end
        return 2'd0;
    endfunction

    function automatic bit want_stall(bit dv, logic [4:0] r1, logic [4:0] r2, bit fl);
`ifdef FWD_LOAD_STALL_EN
        if (m_bubble || !dv || fl || pipe.size() == 0) return 1'b0;
        return pipe[0].live && pipe[0].load && pipe[0].wen && pipe[0].rd != 5'd0 &&
               (pipe[0].rd == r1 || pipe[0].rd == r2);
`else
        return 1'b0;
`endif
    endfunction

    function automatic void model_reset();
        pipe.delete();
        m_bubble = 1'b0;
        m_sa = 2'd0;
        m_sb = 2'd0;
    endfunction

    function automatic void push_ins(ins_t e);
        pipe.push_front(e);
        if (pipe.size() > 3) void'(pipe.pop_back());
    endfunction

    // One cycle of stimulus; expectations go to the scoreboard
    task automatic drive(input bit dv, input logic [4:0] r1, input logic [4:0] r2,
                         input logic [4:0] rd, input bit wen, input bit ld,
                         input bit fl, input bit hd);
        ins_t e;
        bit   st;
        reg_exp_t   re;
        stall_exp_t se;
        @(posedge clk);
        #1;
        dec_valid = dv; dec_rs1 = r1; dec_rs2 = r2; dec_rd = rd;
        dec_regwen = wen; dec_is_load = ld; flush = fl; hold = hd;
        st = want_stall(dv, r1, r2, fl);
        se.cyc = cyc_cnt; se.st = st;
        stall_q.push_back(se);
        if (hd) begin
            if (fl) begin
                if (pipe.size() > 0) pipe[0].live = 1'b0;
                m_sa = 2'd0; m_sb = 2'd0;
                m_bubble = 1'b0;
            end
        end else if (st) begin
            e.live = 1'b0; e.wen = 1'b0; e.load = 1'b0; e.rd = 5'd0;
            push_ins(e);
            m_sa = 2'd0; m_sb = 2'd0;
            m_bubble = 1'b1;
        end else begin
            m_sa = (dv && !fl) ? pick(r1) : 2'd0;
            m_sb = (dv && !fl) ? pick(r2) : 2'd0;
            e.live = dv && !fl; e.wen = wen; e.load = ld; e.rd = rd;
            push_ins(e);
            m_bubble = 1'b0;
        end
        re.cyc = cyc_cnt + 1;
        re.sa = m_sa; re.sb = m_sb;
        re.ev = (pipe.size() > 0) && pipe[0].live;
        reg_q.push_back(re);
        last_stall = st && !hd;
    endtask

    // Decode an instruction, re-presenting it while the pipeline asks for a bubble
    task automatic issue(input logic [4:0] r1, input logic [4:0] r2,
                         input logic [4:0] rd, input bit wen, input bit ld);
        drive(1'b1, r1, r2, rd, wen, ld, 1'b0, 1'b0);
        for (int k = 0; k < 4 && last_stall; k++)
            drive(1'b1, r1, r2, rd, wen, ld, 1'b0, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Asynchronous reset in the middle of a cycle: outputs must clear at once and stay clear
    task automatic do_reset();
        reg_exp_t   re;
        stall_exp_t se;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        dec_valid = 1'b0; flush = 1'b0; hold = 1'b0;
        reg_q.delete();
        stall_q.delete();
        model_reset();
        re.sa = 2'd0; re.sb = 2'd0; re.ev = 1'b0;
        re.cyc = cyc_cnt;     reg_q.push_back(re);
        re.cyc = cyc_cnt + 1; reg_q.push_back(re);
        se.st = 1'b0;
        se.cyc = cyc_cnt;     stall_q.push_back(se);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        se.cyc = cyc_cnt;     stall_q.push_back(se);
        re.cyc = cyc_cnt + 1; reg_q.push_back(re);
        last_stall = 1'b0;
    endtask

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0d expected=%0d", name, cyc_cnt, got, exp);
        end
    endtask

    // Monitor: compare whatever the scoreboard says is due this cycle
    always @(negedge clk) begin
        while (stall_q.size() > 0 && stall_q[0].cyc <= cyc_cnt) begin
            stall_exp_t se;
            se = stall_q.pop_front();
            if (se.cyc == cyc_cnt) chk("stall_req", int'(stall_req), int'(se.st));
        end
        while (reg_q.size() > 0 && reg_q[0].cyc <= cyc_cnt) begin
            reg_exp_t re;
            re = reg_q.pop_front();
            if (re.cyc == cyc_cnt) begin
                chk("sel_a", int'(sel_a), int'(re.sa));
                chk("sel_b", int'(sel_b), int'(re.sb));
                chk("ex_valid", int'(ex_valid), int'(re.ev));
            end
        end
    end

    initial begin
        logic [4:0] r1, r2, rd;
        bit wen, ld, dv, fl, hd;
        model_reset();
        last_stall = 1'b0;
        do_reset();
        idle(1);

        // Back-to-back dependency, then a consumer two behind
        issue(5'd1, 5'd2, 5'd5, 1'b1, 1'b0);
        issue(5'd5, 5'd5, 5'd6, 1'b1, 1'b0);
        issue(5'd5, 5'd3, 5'd8, 1'b1, 1'b0);
        idle(2);

        // x0 never forwards; newest of two writers wins
        issue(5'd3, 5'd4, 5'd0, 1'b1, 1'b0);
        issue(5'd0, 5'd0, 5'd2, 1'b1, 1'b0);
        issue(5'd1, 5'd1, 5'd7, 1'b1, 1'b0);
        issue(5'd2, 5'd2, 5'd7, 1'b1, 1'b0);
        issue(5'd7, 5'd7, 5'd3, 1'b1, 1'b0);
        idle(2);

        // Hold for three cycles with changing decode inputs, then a flush of a dependent instr
        issue(5'd0, 5'd0, 5'd4, 1'b1, 1'b0);
        issue(5'd4, 5'd0, 5'd9, 1'b1, 1'b0);
        drive(1'b1, 5'd9, 5'd4, 5'd1, 1'b1, 1'b0, 1'b0, 1'b1);
        drive(1'b1, 5'd3, 5'd9, 5'd2, 1'b1, 1'b0, 1'b0, 1'b1);
        drive(1'b0, 5'd9, 5'd9, 5'd2, 1'b1, 1'b0, 1'b0, 1'b1);
        drive(1'b1, 5'd9, 5'd9, 5'd3, 1'b1, 1'b0, 1'b1, 1'b0);
        issue(5'd9, 5'd4, 5'd5, 1'b1, 1'b0);
        drive(1'b1, 5'd5, 5'd5, 5'd6, 1'b1, 1'b0, 1'b1, 1'b1);
        idle(3);

        // Load-use: lw x9 then add x1,x9,x2
        issue(5'd0, 5'd0, 5'd9, 1'b1, 1'b1);
        issue(5'd9, 5'd2, 5'd1, 1'b1, 1'b0);
        issue(5'd1, 5'd9, 5'd3, 1'b1, 1'b0);
        idle(2);

        // Reset with live slots
        issue(5'd1, 5'd2, 5'd5, 1'b1, 1'b0);
        issue(5'd5, 5'd5, 5'd6, 1'b1, 1'b1);
        do_reset();
        idle(1);

        // Randomized traffic over a small register range to force plenty of hazards
        for (int i = 0; i < 1500; i++) begin
            if (!last_stall) begin
                dv  = ($urandom_range(0, 9) < 8);
                r1  = 5'($urandom_range(0, 7));
                r2  = 5'($urandom_range(0, 7));
                rd  = 5'($urandom_range(0, 7));
                wen = ($urandom_range(0, 9) < 8);
                ld  = ($urandom_range(0, 9) < 3);
            end
            fl = ($urandom_range(0, 99) < 8);
            hd = ($urandom_range(0, 99) < 10);
            drive(dv, r1, r2, rd, wen, ld, fl, hd);
        end
        idle(3);

        // Drain the scoreboard with a bounded wait
        for (int k = 0; k < 10 && (reg_q.size() > 0 || stall_q.size() > 0); k++)
            @(negedge clk);
        #1;
        checks++;
        if (reg_q.size() > 0 || stall_q.size() > 0) begin
            errors++;
            $display("FAIL drain pending=%0d expected=0", reg_q.size() + stall_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
